// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: PC, busywait instruction fetch, decode, j/beq redirect.
// Define ILLEGAL_HALT_EN to park in HALT on an undefined opcode instead of skipping it.
module fetch_decode_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic                IMEM_READ,
    output logic [PC_WIDTH-1:0] IMEM_ADDR,
    input  logic                IMEM_BUSYWAIT,
    input  logic [31:0]         IMEM_INSTR,
    input  logic                STALL,
    input  logic                ZERO,
    output logic [PC_WIDTH-1:0] PC,
    output logic [7:0]          OPCODE,
    output logic [2:0]          WRITEREG,
    output logic [2:0]          READREG1,
    output logic [2:0]          READREG2,
    output logic [7:0]          IMMEDIATE,
    output logic                WRITEENABLE,
    output logic                INSTR_VALID,
    output logic                ILLEGAL
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
`ifdef ILLEGAL_HALT_EN
        ISSUE = 2'd2,
        HALT  = 2'd3
`else
        ISSUE = 2'd2
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;

    logic                op_write, op_jump, op_beq, op_illegal;
    logic [PC_WIDTH-1:0] pc_seq, br_off, pc_br;
    logic                unused_ir;

    assign unused_ir = ^ir_q[15:11];

    assign OPCODE    = ir_q[31:24];
    assign WRITEREG  = ir_q[18:16];
    assign READREG1  = ir_q[10:8];
    assign READREG2  = ir_q[2:0];
    assign IMMEDIATE = ir_q[7:0];
    assign PC        = pc_q;
    assign IMEM_ADDR = pc_q;

    always_comb begin
        op_write   = 1'b0;
        op_jump    = 1'b0;
        op_beq     = 1'b0;
        op_illegal = 1'b0;
        unique case (ir_q[31:24])
            8'h00, 8'h01, 8'h02,
            8'h03, 8'h04, 8'h05: op_write = 1'b1;
            8'h06:               op_jump  = 1'b1;
            8'h07:               op_beq   = 1'b1;
            default:             op_illegal = 1'b1;
        endcase
    end

    // Branch offset is a signed word count relative to the next sequential PC.
    assign pc_seq = pc_q + {{(PC_WIDTH-3){1'b0}}, 3'd4};
    assign br_off = {{(PC_WIDTH-10){ir_q[23]}}, ir_q[23:16], 2'b00};
    assign pc_br  = pc_seq + br_off;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        IMEM_READ   = 1'b0;
        INSTR_VALID = 1'b0;
        WRITEENABLE = 1'b0;
        ILLEGAL     = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                IMEM_READ = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    ir_d    = IMEM_INSTR;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                INSTR_VALID = 1'b1;
                WRITEENABLE = op_write;
                ILLEGAL     = op_illegal;
                if (!STALL) begin
`ifdef ILLEGAL_HALT_EN
                    if (op_illegal) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                        pc_d    = (op_jump || (op_beq && ZERO)) ? pc_br : pc_seq;
                    end
`else
                    state_d = FETCH;
                    pc_d    = (op_jump || (op_beq && ZERO)) ? pc_br : pc_seq;
`endif
                end
            end
`ifdef ILLEGAL_HALT_EN
            HALT: ILLEGAL = 1'b1;
`endif
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: directed fetch vectors, negedge monitor.
// With ILLEGAL_HALT_EN the run stops at the illegal opcode and checks HALT.
module tb_fetch_decode_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_BUSYWAIT = 1'b1;
    logic [31:0] IMEM_INSTR = '0;
    logic        STALL = 1'b0;
    logic        ZERO = 1'b0;
    logic [31:0] PC;
    logic [7:0]  OPCODE;
    logic [2:0]  WRITEREG;
    logic [2:0]  READREG1;
    logic [2:0]  READREG2;
    logic [7:0]  IMMEDIATE;
    logic        WRITEENABLE;
    logic        INSTR_VALID;
    logic        ILLEGAL;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int rd_cnt = 0;
    int iss_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          busy;
        logic        zero;
        int          stall;
        logic [7:0]  op;
        logic [2:0]  wr;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [7:0]  imm;
        logic        we;
        logic        ill;
    } vec_t;

`ifdef ILLEGAL_HALT_EN
    localparam int NV = 3;
`else
    localparam int NV = 10;
`endif

    vec_t vecs[10];
    vec_t exp_q[$];

    fetch_decode_unit #(
        .PC_WIDTH(32),
        .RESET_PC(32'h0)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IMEM_READ(IMEM_READ),
        .IMEM_ADDR(IMEM_ADDR),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IMEM_INSTR(IMEM_INSTR),
        .STALL(STALL),
        .ZERO(ZERO),
        .PC(PC),
        .OPCODE(OPCODE),
        .WRITEREG(WRITEREG),
        .READREG1(READREG1),
        .READREG2(READREG2),
        .IMMEDIATE(IMMEDIATE),
        .WRITEENABLE(WRITEENABLE),
        .INSTR_VALID(INSTR_VALID),
        .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic check_reset();
        chk("rst_read", IMEM_READ, 0);
        chk("rst_addr", IMEM_ADDR, 0);
        chk("rst_pc", PC, 0);
        chk("rst_opcode", OPCODE, 0);
        chk("rst_wreg", WRITEREG, 0);
        chk("rst_rreg1", READREG1, 0);
        chk("rst_rreg2", READREG2, 0);
        chk("rst_imm", IMMEDIATE, 0);
        chk("rst_we", WRITEENABLE, 0);
        chk("rst_valid", INSTR_VALID, 0);
        chk("rst_illegal", ILLEGAL, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!IMEM_READ && n < 100);
        if (!IMEM_READ) begin
            chk("fetch_timeout", 0, 1);
            finish_now();
        end
        exp_q.push_back(v);
        IMEM_BUSYWAIT = 1'b1;
        repeat (v.busy) begin
            @(posedge CLK); #1;
        end
        IMEM_INSTR = v.instr;
        ZERO = v.zero;
        IMEM_BUSYWAIT = 1'b0;
        @(posedge CLK); #1;
        IMEM_BUSYWAIT = 1'b1;
        STALL = (v.stall > 0);
        repeat (v.stall) begin
            @(posedge CLK); #1;
        end
        STALL = 1'b0;
    endtask

    // Monitor: every fetch cycle and every issue cycle is compared
    // against the record at the head of the scoreboard.
    always @(negedge CLK) begin
        vec_t e;
        if (mon_en) begin
            if (IMEM_READ) begin
                if (exp_q.size() == 0) begin
                    chk("read_unexpected", 1, 0);
                end else begin
                    chk("imem_addr", IMEM_ADDR, exp_q[0].addr);
                    rd_cnt++;
                end
            end
            if (INSTR_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("issue_pc", PC, e.addr);
                    chk("opcode", OPCODE, e.op);
                    chk("writereg", WRITEREG, e.wr);
                    chk("readreg1", READREG1, e.r1);
                    chk("readreg2", READREG2, e.r2);
                    chk("immediate", IMMEDIATE, e.imm);
                    chk("writeenable", WRITEENABLE, e.we);
                    chk("illegal", ILLEGAL, e.ill);
                    chk("issue_read_low", IMEM_READ, 0);
                    iss_cnt++;
                    if (!STALL) begin
                        chk("fetch_cycles", rd_cnt, e.busy + 1);
                        chk("issue_cycles", iss_cnt, e.stall + 1);
                        void'(exp_q.pop_front());
                        rd_cnt = 0;
                        iss_cnt = 0;
                    end
                end
            end else begin
                chk("we_idle", WRITEENABLE, 0);
                chk("illegal_idle", ILLEGAL, 0);
            end
        end
    end

    initial begin
        #100000;
        chk("watchdog", 0, 1);
        finish_now();
    end

    initial begin
        //           addr          instr        busy zero stall op     wr    r1    r2    imm    we    ill
        vecs[0] = '{32'h00000000, 32'h00020005, 0, 1'b0, 0, 8'h00, 3'd2, 3'd0, 3'd5, 8'h05, 1'b1, 1'b0};
        vecs[1] = '{32'h00000004, 32'h02030102, 3, 1'b0, 0, 8'h02, 3'd3, 3'd1, 3'd2, 8'h02, 1'b1, 1'b0};
        vecs[2] = '{32'h00000008, 32'hFF000000, 1, 1'b0, 0, 8'hFF, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{32'h0000000C, 32'h03040506, 0, 1'b0, 2, 8'h03, 3'd4, 3'd5, 3'd6, 8'h06, 1'b1, 1'b0};
        vecs[4] = '{32'h00000010, 32'h07FE0102, 0, 1'b1, 0, 8'h07, 3'd6, 3'd1, 3'd2, 8'h02, 1'b0, 1'b0};
        vecs[5] = '{32'h0000000C, 32'h01050007, 2, 1'b1, 0, 8'h01, 3'd5, 3'd0, 3'd7, 8'h07, 1'b1, 1'b0};
        vecs[6] = '{32'h00000010, 32'h07FE0102, 0, 1'b0, 0, 8'h07, 3'd6, 3'd1, 3'd2, 8'h02, 1'b0, 1'b0};
        vecs[7] = '{32'h00000014, 32'h06F90000, 0, 1'b0, 1, 8'h06, 3'd1, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{32'hFFFFFFFC, 32'h067F0000, 0, 1'b0, 0, 8'h06, 3'd7, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{32'h000001FC, 32'h05010203, 1, 1'b0, 0, 8'h05, 3'd1, 3'd2, 3'd3, 8'h03, 1'b1, 1'b0};

        #2 RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset();
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("idle_read", IMEM_READ, 0);
        mon_en = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        @(posedge CLK); #1;
        mon_en = 1'b0;
`ifdef ILLEGAL_HALT_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("halt_illegal", ILLEGAL, 1);
            chk("halt_read", IMEM_READ, 0);
            chk("halt_pc", PC, 32'h8);
            chk("halt_valid", INSTR_VALID, 0);
            chk("halt_we", WRITEENABLE, 0);
        end
        @(posedge CLK); #1;
`else
        chk("last_read", IMEM_READ, 1);
        chk("last_addr", IMEM_ADDR, 32'h200);
        @(posedge CLK); #1;
`endif
        // Reset lands while a memory response is being offered.
        RESET = 1'b0;
        IMEM_INSTR = 32'h0000FFFF;
        IMEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        check_reset();
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("post_idle_read", IMEM_READ, 0);
        chk("post_imm", IMMEDIATE, 0);
        chk("post_opcode", OPCODE, 0);
        @(negedge CLK);
        chk("post_fetch_read", IMEM_READ, 1);
        chk("post_fetch_addr", IMEM_ADDR, 0);
        IMEM_BUSYWAIT = 1'b1;
        repeat (2) @(posedge CLK);
        finish_now();
    end

endmodule
